dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 16, address width; DATA_WIDTH, default 16, data width; STARVE_LIMIT, default 4, maximum cycles a buffered write may wait.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rd_req  input  1  operand-fetch stage requests a data read.
REQ-005 rd_addr  input  ADDR_WIDTH  read address.
REQ-006 rd_gnt  output  1  combinational; read accepted this cycle.
REQ-007 rd_valid  output  1  registered; rd_data valid, one-cycle pulse per granted read.
REQ-008 rd_data  output  DATA_WIDTH  registered read data.
REQ-009 wr_req  input  1  writeback stage requests a data write.
REQ-010 wr_addr  input  ADDR_WIDTH  write address.
REQ-011 wr_data  input  DATA_WIDTH  write data.
REQ-012 wr_gnt  output  1  combinational; write accepted into the write buffer this cycle.
REQ-013 mem_addr  output  ADDR_WIDTH  registered SRAM address.
REQ-014 mem_data_out  output  DATA_WIDTH  registered SRAM write data.
REQ-015 mem_we_n  output  1  registered SRAM write enable, active-low.
REQ-016 mem_data_in  input  DATA_WIDTH  asynchronous SRAM read data, valid within the cycle after mem_addr updates.

Function
REQ-017 The block SHALL hold one write-buffer entry: wb_valid, wb_addr, wb_data, and an age counter.
REQ-018 wr_gnt SHALL equal wr_req AND (NOT wb_valid OR drain this cycle); a granted write SHALL load the buffer at the next edge.
REQ-019 Drain SHALL be selected when wb_valid AND (NOT rd_req OR age >= STARVE_LIMIT OR wr_req with a full buffer OR unforwardable address hazard).
REQ-020 On drain: mem_addr<=wb_addr, mem_data_out<=wb_data, mem_we_n<=0 for exactly one cycle; wb_valid and age SHALL clear at the same edge unless a new write loads.
REQ-021 rd_gnt SHALL equal rd_req AND NOT drain; a granted SRAM read at edge N SHALL set mem_addr<=rd_addr, mem_we_n<=1; at edge N+1, rd_data<=mem_data_in and rd_valid<=1.
REQ-022 Back-to-back reads SHALL sustain one grant per cycle; rd_valid follows each grant by exactly one cycle.
REQ-023 Age SHALL increment each cycle wb_valid is high without drain, saturating at STARVE_LIMIT.
REQ-024 Read-after-write ordering SHALL hold: a read never returns data older than a buffered write, or a same-cycle granted write, to the same address.
REQ-025 No state SHALL issue simultaneous read and write on the SRAM port; mem_we_n SHALL be 1 in every non-drain cycle.
REQ-026 Simultaneous rd_req and wr_req with an empty buffer and differing addresses: both granted; read goes to SRAM; write buffered.

Reset
REQ-027 While reset is high at an edge: wb_valid=0, age=0, rd_valid=0, rd_data=0, mem_addr=0, mem_data_out=0, mem_we_n=1.
REQ-028 Reset asserted mid-operation SHALL discard any buffered write and suppress any pending rd_valid; rd_gnt=wr_gnt=0 during reset.

Configuration
REQ-029 Macro DMEM_ARB_BYPASS_EN defined: an address match with wb_addr (or with a same-cycle granted wr_addr, which takes precedence) SHALL grant the read without SRAM access and return the matched data with standard one-cycle latency.
REQ-030 DMEM_ARB_BYPASS_EN undefined: a buffer-address match SHALL force drain with rd_gnt=0 that cycle; a same-cycle wr_addr match with an empty buffer SHALL hold rd_gnt=0 until the write drains.

Structure
REQ-031 Package cpu_pkg SHALL hold ADDR_WIDTH/DATA_WIDTH defaults, STARVE_LIMIT default and the port-operation enum (IDLE, READ, WRITE, FWD).
REQ-032 Sub-module dmem_wbuf SHALL implement the write-buffer entry and age counter; arbitration remains in dmem_arbiter.

Verification
REQ-033 Single read: rd_req, rd_addr=0x0010, SRAM holds 0xBEEF -> rd_gnt same cycle, rd_valid next cycle with rd_data=0xBEEF, mem_we_n stays 1.
REQ-034 Write then idle: wr_req, wr_addr=0x0020, wr_data=0x1234 -> wr_gnt; next cycle mem_we_n=0, mem_addr=0x0020, mem_data_out=0x1234 for one cycle.
REQ-035 Starvation: buffered write plus continuous reads to 0x0001..0x0008 -> drain after exactly 4 read cycles; rd_gnt low exactly one cycle.
REQ-036 RAW hazard: write 0x0030=0x5555 buffered, read 0x0030 next cycle -> with macro rd_data=0x5555 with no SRAM access; without macro drain first, then rd_data=0x5555.
REQ-037 Reset mid-drain: reset asserted during mem_we_n=0 -> next edge mem_we_n=1, wb_valid=0, rd_valid=0.
REQ-038 Full buffer plus new write and read: drain wins, rd_gnt=0, new write granted same cycle, read granted next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and defaults for the data-memory arbiter and its write buffer.
package cpu_pkg;

  localparam int unsigned ADDR_WIDTH_DEF   = 16;
  localparam int unsigned DATA_WIDTH_DEF   = 16;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  // Operation issued on the SRAM port at the most recent edge.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    FWD   = 2'd3
  } port_op_e;

  // Bits needed to count from 0 up to and including limit.
  function automatic int unsigned age_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Pipeline-side read/write handshakes plus the single-port SRAM bus.
// slave: the arbiter. master: the pipeline stages and SRAM around it.
interface dmem_arbiter_if
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_gnt;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;

  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_gnt;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic                  mem_we_n;
  logic [DATA_WIDTH-1:0] mem_data_in;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_data_in,
    output rd_gnt, rd_valid, rd_data, wr_gnt, mem_addr, mem_data_out, mem_we_n
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_data_in,
    input  rd_gnt, rd_valid, rd_data, wr_gnt, mem_addr, mem_data_out, mem_we_n
  );

endinterface

// File: rtl/dmem_wbuf.sv
// Single-entry write buffer with a saturating age counter.
// A load always starts a fresh entry at age 0; load wins over drain because the
// arbiter only loads when the slot is empty or being drained in the same cycle.
module dmem_wbuf
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  drain_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  starved_o
);

  localparam int unsigned      AGE_W   = age_width(STARVE_LIMIT);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [AGE_W-1:0]      age_q, age_d;

  // Next entry contents: load, drain, or age the waiting write.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    age_d   = age_q;
    if (load_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
      data_d  = data_i;
      age_d   = '0;
    end else if (drain_i) begin
      valid_d = 1'b0;
      age_d   = '0;
    end else if (valid_q && (age_q < AGE_MAX)) begin
      age_d = age_q + AGE_W'(1);
    end
  end

  // Entry registers; reset discards any buffered write.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      age_q   <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      age_q   <= age_d;
    end
  end

  assign valid_o   = valid_q;
  assign addr_o    = addr_q;
  assign data_o    = data_q;
  assign starved_o = valid_q && (age_q >= AGE_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: operand-fetch reads vs. buffered writeback writes on one
// single-port SRAM. Reads go straight through unless the buffered write must
// drain; writes park in a one-entry buffer and drain on idle read cycles, on
// starvation, on a new write, or on an address hazard.
// Optional build macro DMEM_ARB_BYPASS_EN: reads that hit the buffered write
// (or a same-cycle write) are served from the arbiter without touching SRAM.
//
// op_q   | meaning
// IDLE   | no SRAM access issued at the last edge
// READ   | SRAM read issued; capture mem_data_in at the next edge
// WRITE  | buffered write driven onto SRAM (mem_we_n low this cycle)
// FWD    | read served from forwarded write data; no SRAM access
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  logic                  wb_valid;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  wb_starved;

  logic                  hit_buf;
  logic                  hit_wr;
  logic                  drain;
  logic                  rd_gnt;
  logic                  wr_gnt;
  logic                  fwd_sel;
  logic [DATA_WIDTH-1:0] fwd_data;

  port_op_e              op_q;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_data_q;
  logic                  mem_we_n_q;

  dmem_wbuf #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_wbuf (
    .clk      (clk),
    .reset    (reset),
    .load_i   (wr_gnt),
    .drain_i  (drain),
    .addr_i   (bus.wr_addr),
    .data_i   (bus.wr_data),
    .valid_o  (wb_valid),
    .addr_o   (wb_addr),
    .data_o   (wb_data),
    .starved_o(wb_starved)
  );

  // Arbitration: drain has priority over reads; a full buffer never blocks a
  // write because a pending write always forces the drain.
  always_comb begin
    hit_buf = wb_valid && (bus.rd_addr == wb_addr);
    hit_wr  = bus.wr_req && (bus.rd_addr == bus.wr_addr);
`ifdef DMEM_ARB_BYPASS_EN
    drain    = !reset && wb_valid &&
               (!bus.rd_req || wb_starved || bus.wr_req);
    wr_gnt   = !reset && bus.wr_req && (!wb_valid || drain);
    rd_gnt   = !reset && bus.rd_req && !drain;
    // A granted read with wr_req high implies an empty buffer, so the
    // same-cycle write is the youngest copy of that address.
    fwd_sel  = hit_wr || hit_buf;
    fwd_data = hit_wr ? bus.wr_data : wb_data;
`else
    drain    = !reset && wb_valid &&
               (!bus.rd_req || wb_starved || bus.wr_req || hit_buf);
    wr_gnt   = !reset && bus.wr_req && (!wb_valid || drain);
    // A read to the address being written this cycle waits until that write
    // has reached SRAM.
    rd_gnt   = !reset && bus.rd_req && !drain && !(hit_wr && wr_gnt);
    fwd_sel  = 1'b0;
    fwd_data = '0;
`endif
  end

  // Port FSM: issue one SRAM operation per edge and return read data one
  // edge after its grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= IDLE;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      fwd_data_q <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_n_q <= 1'b1;
    end else begin
      rd_valid_q <= (op_q == READ) || (op_q == FWD);
      if (op_q == READ) begin
        rd_data_q <= bus.mem_data_in;
      end else if (op_q == FWD) begin
        rd_data_q <= fwd_data_q;
      end
      mem_we_n_q <= 1'b1;
      if (drain) begin
        op_q       <= WRITE;
        mem_addr_q <= wb_addr;
        mem_data_q <= wb_data;
        mem_we_n_q <= 1'b0;
      end else if (rd_gnt && fwd_sel) begin
        op_q       <= FWD;
        fwd_data_q <= fwd_data;
      end else if (rd_gnt) begin
        op_q       <= READ;
        mem_addr_q <= bus.rd_addr;
      end else begin
        op_q <= IDLE;
      end
    end
  end

  assign bus.rd_gnt       = rd_gnt;
  assign bus.wr_gnt       = wr_gnt;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_data_out = mem_data_q;
  assign bus.mem_we_n     = mem_we_n_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural asynchronous-read SRAM.
module tb_dmem_arbiter;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  dmem_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

  dmem_arbiter #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .STARVE_LIMIT(4)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Default SRAM contents for never-written words.
  function automatic logic [15:0] pat(input logic [15:0] a);
    if (a == 16'h0010) return 16'hBEEF;
    return {a[7:0] ^ 8'h5A, a[7:0]};
  endfunction

  logic [15:0]  mem [256];
  logic [255:0] wflag = '0;

  always @(posedge clk) begin
    if (bus.mem_we_n === 1'b0) begin
      mem[bus.mem_addr[7:0]]   <= bus.mem_data_out;
      wflag[bus.mem_addr[7:0]] <= 1'b1;
    end
  end

  assign bus.mem_data_in = wflag[bus.mem_addr[7:0]] ? mem[bus.mem_addr[7:0]]
                                                   : pat(bus.mem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rr, input logic [15:0] ra,
                       input logic wr, input logic [15:0] wa, input logic [15:0] wd);
    bus.rd_req  = rr;
    bus.rd_addr = ra;
    bus.wr_req  = wr;
    bus.wr_addr = wa;
    bus.wr_data = wd;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 16'h0010, 1'b1, 16'h0020, 16'h1234);
    tick(); tick();
    #1;
    total++;
    if ({bus.rd_gnt, bus.wr_gnt} !== 2'b00) begin
      bad++; $display("FAIL reset_gnt got=%b want=00", {bus.rd_gnt, bus.wr_gnt});
    end
    total++;
    if ({bus.mem_we_n, bus.mem_addr, bus.mem_data_out, bus.rd_valid, bus.rd_data} !==
        {1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000}) begin
      bad++; $display("FAIL reset_regs got we_n=%b addr=%h dout=%h rv=%b rd=%h",
                      bus.mem_we_n, bus.mem_addr, bus.mem_data_out, bus.rd_valid, bus.rd_data);
    end
    reset = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    tick(); tick();
    total++;
    if (bus.mem_we_n !== 1'b1) begin
      bad++; $display("FAIL reset_no_write got we_n=%b want=1", bus.mem_we_n);
    end
  endtask

  task automatic test_single_read();
    drive(1'b1, 16'h0010, 1'b0, 16'h0, 16'h0);
    #1;
    total++;
    if ({bus.rd_gnt, bus.wr_gnt} !== 2'b10) begin
      bad++; $display("FAIL sread_gnt got=%b want=10", {bus.rd_gnt, bus.wr_gnt});
    end
    tick();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    total++;
    if ({bus.mem_we_n, bus.mem_addr, bus.rd_valid} !== {1'b1, 16'h0010, 1'b0}) begin
      bad++; $display("FAIL sread_issue got we_n=%b addr=%h rv=%b want 1 0010 0",
                      bus.mem_we_n, bus.mem_addr, bus.rd_valid);
    end
    tick();
    total++;
    if ({bus.rd_valid, bus.rd_data, bus.mem_we_n} !== {1'b1, 16'hBEEF, 1'b1}) begin
      bad++; $display("FAIL sread_data got rv=%b rd=%h we_n=%b want 1 beef 1",
                      bus.rd_valid, bus.rd_data, bus.mem_we_n);
    end
    tick();
    total++;
    if (bus.rd_valid !== 1'b0) begin
      bad++; $display("FAIL sread_pulse got rv=%b want=0", bus.rd_valid);
    end
  endtask

  task automatic test_write_idle();
    drive(1'b0, 16'h0, 1'b1, 16'h0020, 16'h1234);
    #1;
    total++;
    if ({bus.rd_gnt, bus.wr_gnt} !== 2'b01) begin
      bad++; $display("FAIL wr_gnt got=%b want=01", {bus.rd_gnt, bus.wr_gnt});
    end
    tick();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    total++;
    if (bus.mem_we_n !== 1'b1) begin
      bad++; $display("FAIL wr_buffered got we_n=%b want=1", bus.mem_we_n);
    end
    tick();
    total++;
    if ({bus.mem_we_n, bus.mem_addr, bus.mem_data_out} !== {1'b0, 16'h0020, 16'h1234}) begin
      bad++; $display("FAIL wr_drain got we_n=%b addr=%h dout=%h want 0 0020 1234",
                      bus.mem_we_n, bus.mem_addr, bus.mem_data_out);
    end
    tick();
    total++;
    if (bus.mem_we_n !== 1'b1) begin
      bad++; $display("FAIL wr_one_cycle got we_n=%b want=1", bus.mem_we_n);
    end
    drive(1'b1, 16'h0020, 1'b0, 16'h0, 16'h0);
    tick();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    tick();
    total++;
    if ({bus.rd_valid, bus.rd_data} !== {1'b1, 16'h1234}) begin
      bad++; $display("FAIL wr_readback got rv=%b rd=%h want 1 1234", bus.rd_valid, bus.rd_data);
    end
  endtask

  task automatic test_both_grant();
    drive(1'b1, 16'h0011, 1'b1, 16'h0070, 16'h0BAD);
    #1;
    total++;
    if ({bus.rd_gnt, bus.wr_gnt} !== 2'b11) begin
      bad++; $display("FAIL both_gnt got=%b want=11", {bus.rd_gnt, bus.wr_gnt});
    end
    tick();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    total++;
    if ({bus.mem_we_n, bus.mem_addr} !== {1'b1, 16'h0011}) begin
      bad++; $display("FAIL both_read_issue got we_n=%b addr=%h want 1 0011",
                      bus.mem_we_n, bus.mem_addr);
    end
    tick();
    total++;
    if ({bus.rd_valid, bus.rd_data, bus.mem_we_n, bus.mem_addr, bus.mem_data_out} !==
        {1'b1, pat(16'h0011), 1'b0, 16'h0070, 16'h0BAD}) begin
      bad++; $display("FAIL both_result got rv=%b rd=%h we_n=%b addr=%h dout=%h",
                      bus.rd_valid, bus.rd_data, bus.mem_we_n, bus.mem_addr, bus.mem_data_out);
    end
    tick();
  endtask

  task automatic test_starvation();
    bit          gexp [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [15:0] a      = 16'h0001;
    logic [15:0] prev_a = 16'h0000;
    bit          prev_g = 1'b0;
    bit          g;
    drive(1'b0, 16'h0, 1'b1, 16'h0040, 16'h7777);
    tick();
    for (int c = 0; c < 9; c++) begin
      drive(1'b1, a, 1'b0, 16'h0, 16'h0);
      #1;
      g = gexp[c];
      total++;
      if (bus.rd_gnt !== g) begin
        bad++; $display("FAIL starve_gnt cyc=%0d got=%b want=%b", c, bus.rd_gnt, g);
      end
      tick();
      total++;
      if ({bus.mem_we_n, bus.mem_addr, bus.rd_valid} !== {g, (g ? a : 16'h0040), prev_g}) begin
        bad++; $display("FAIL starve_port cyc=%0d got we_n=%b addr=%h rv=%b want %b %h %b",
                        c, bus.mem_we_n, bus.mem_addr, bus.rd_valid, g, (g ? a : 16'h0040), prev_g);
      end
      if (prev_g) begin
        total++;
        if (bus.rd_data !== pat(prev_a)) begin
          bad++; $display("FAIL starve_data cyc=%0d got=%h want=%h", c, bus.rd_data, pat(prev_a));
        end
      end
      prev_g = g;
      prev_a = a;
      if (g) a = a + 16'h0001;
    end
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    tick();
    total++;
    if ({bus.rd_valid, bus.rd_data} !== {1'b1, pat(16'h0008)}) begin
      bad++; $display("FAIL starve_last got rv=%b rd=%h want 1 %h", bus.rd_valid, bus.rd_data, pat(16'h0008));
    end
    tick();
  endtask

  task automatic test_raw_buffered();
    drive(1'b0, 16'h0, 1'b1, 16'h0030, 16'h5555);
    tick();
    drive(1'b1, 16'h0030, 1'b0, 16'h0, 16'h0);
    #1;
`ifdef DMEM_ARB_BYPASS_EN
    total++;
    if (bus.rd_gnt !== 1'b1) begin
      bad++; $display("FAIL raw_gnt got=%b want=1", bus.rd_gnt);
    end
    tick();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    total++;
    if (bus.mem_we_n !== 1'b1) begin
      bad++; $display("FAIL raw_no_sram got we_n=%b want=1", bus.mem_we_n);
    end
    tick();
    total++;
    if ({bus.rd_valid, bus.rd_data, bus.mem_we_n, bus.mem_addr} !== {1'b1, 16'h5555, 1'b0, 16'h0030}) begin
      bad++; $display("FAIL raw_fwd got rv=%b rd=%h we_n=%b addr=%h",
                      bus.rd_valid, bus.rd_data, bus.mem_we_n, bus.mem_addr);
    end
`else
    total++;
    if (bus.rd_gnt !== 1'b0) begin
      bad++; $display("FAIL raw_block got=%b want=0", bus.rd_gnt);
    end
    tick();
    total++;
    if ({bus.mem_we_n, bus.mem_addr, bus.mem_data_out} !== {1'b0, 16'h0030, 16'h5555}) begin
      bad++; $display("FAIL raw_drain got we_n=%b addr=%h dout=%h want 0 0030 5555",
                      bus.mem_we_n, bus.mem_addr, bus.mem_data_out);
    end
    #1;
    total++;
    if (bus.rd_gnt !== 1'b1) begin
      bad++; $display("FAIL raw_regrant got=%b want=1", bus.rd_gnt);
    end
    tick();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    tick();
    total++;
    if ({bus.rd_valid, bus.rd_data} !== {1'b1, 16'h5555}) begin
      bad++; $display("FAIL raw_data got rv=%b rd=%h want 1 5555", bus.rd_valid, bus.rd_data);
    end
`endif
    tick();
  endtask

  task automatic test_raw_same_cycle();
    drive(1'b1, 16'h0050, 1'b1, 16'h0050, 16'hAAAA);
    #1;
`ifdef DMEM_ARB_BYPASS_EN
    total++;
    if ({bus.rd_gnt, bus.wr_gnt} !== 2'b11) begin
      bad++; $display("FAIL samecyc_gnt got=%b want=11", {bus.rd_gnt, bus.wr_gnt});
    end
    tick();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    tick();
    total++;
    if ({bus.rd_valid, bus.rd_data, bus.mem_we_n} !== {1'b1, 16'hAAAA, 1'b0}) begin
      bad++; $display("FAIL samecyc_data got rv=%b rd=%h we_n=%b want 1 aaaa 0",
                      bus.rd_valid, bus.rd_data, bus.mem_we_n);
    end
`else
    total++;
    if ({bus.rd_gnt, bus.wr_gnt} !== 2'b01) begin
      bad++; $display("FAIL samecyc_gnt got=%b want=01", {bus.rd_gnt, bus.wr_gnt});
    end
    tick();
    drive(1'b1, 16'h0050, 1'b0, 16'h0, 16'h0);
    #1;
    total++;
    if (bus.rd_gnt !== 1'b0) begin
      bad++; $display("FAIL samecyc_hold got=%b want=0", bus.rd_gnt);
    end
    tick();
    total++;
    if ({bus.mem_we_n, bus.mem_addr} !== {1'b0, 16'h0050}) begin
      bad++; $display("FAIL samecyc_drain got we_n=%b addr=%h want 0 0050", bus.mem_we_n, bus.mem_addr);
    end
    #1;
    total++;
    if (bus.rd_gnt !== 1'b1) begin
      bad++; $display("FAIL samecyc_regrant got=%b want=1", bus.rd_gnt);
    end
    tick();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    tick();
    total++;
    if ({bus.rd_valid, bus.rd_data} !== {1'b1, 16'hAAAA}) begin
      bad++; $display("FAIL samecyc_data got rv=%b rd=%h want 1 aaaa", bus.rd_valid, bus.rd_data);
    end
`endif
    tick();
  endtask

  task automatic test_full_write_read();
    drive(1'b0, 16'h0, 1'b1, 16'h0080, 16'h1111);
    tick();
    drive(1'b1, 16'h0012, 1'b1, 16'h0081, 16'h2222);
    #1;
    total++;
    if ({bus.rd_gnt, bus.wr_gnt} !== 2'b01) begin
      bad++; $display("FAIL full_gnt got=%b want=01", {bus.rd_gnt, bus.wr_gnt});
    end
    tick();
    drive(1'b1, 16'h0012, 1'b0, 16'h0, 16'h0);
    total++;
    if ({bus.mem_we_n, bus.mem_addr, bus.mem_data_out} !== {1'b0, 16'h0080, 16'h1111}) begin
      bad++; $display("FAIL full_drain got we_n=%b addr=%h dout=%h want 0 0080 1111",
                      bus.mem_we_n, bus.mem_addr, bus.mem_data_out);
    end
    #1;
    total++;
    if (bus.rd_gnt !== 1'b1) begin
      bad++; $display("FAIL full_read_next got=%b want=1", bus.rd_gnt);
    end
    tick();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    total++;
    if ({bus.mem_we_n, bus.mem_addr} !== {1'b1, 16'h0012}) begin
      bad++; $display("FAIL full_read_issue got we_n=%b addr=%h want 1 0012", bus.mem_we_n, bus.mem_addr);
    end
    tick();
    total++;
    if ({bus.rd_valid, bus.rd_data, bus.mem_we_n, bus.mem_addr, bus.mem_data_out} !==
        {1'b1, pat(16'h0012), 1'b0, 16'h0081, 16'h2222}) begin
      bad++; $display("FAIL full_result got rv=%b rd=%h we_n=%b addr=%h dout=%h",
                      bus.rd_valid, bus.rd_data, bus.mem_we_n, bus.mem_addr, bus.mem_data_out);
    end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    drive(1'b0, 16'h0, 1'b1, 16'h0090, 16'h3333);
    tick();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    tick();
    total++;
    if ({bus.mem_we_n, bus.mem_addr} !== {1'b0, 16'h0090}) begin
      bad++; $display("FAIL rstmid_setup got we_n=%b addr=%h want 0 0090", bus.mem_we_n, bus.mem_addr);
    end
    reset = 1'b1;
    drive(1'b1, 16'h0013, 1'b1, 16'h0091, 16'h4444);
    #1;
    total++;
    if ({bus.rd_gnt, bus.wr_gnt} !== 2'b00) begin
      bad++; $display("FAIL rstmid_gnt got=%b want=00", {bus.rd_gnt, bus.wr_gnt});
    end
    tick();
    total++;
    if ({bus.mem_we_n, bus.rd_valid, bus.mem_addr, bus.mem_data_out} !== {1'b1, 1'b0, 16'h0, 16'h0}) begin
      bad++; $display("FAIL rstmid_regs got we_n=%b rv=%b addr=%h dout=%h",
                      bus.mem_we_n, bus.rd_valid, bus.mem_addr, bus.mem_data_out);
    end
    reset = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    tick(); tick();
    total++;
    if (bus.mem_we_n !== 1'b1) begin
      bad++; $display("FAIL rstmid_no_write got we_n=%b want=1", bus.mem_we_n);
    end
    // Buffered write present when reset hits must never reach SRAM.
    drive(1'b0, 16'h0, 1'b1, 16'h0095, 16'h5151);
    tick();
    reset = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (bus.mem_we_n !== 1'b1) begin
        bad++; $display("FAIL rstmid_discard cyc=%0d got we_n=%b want=1", i, bus.mem_we_n);
      end
    end
    // Read granted just before reset must not produce rd_valid.
    drive(1'b1, 16'h0014, 1'b0, 16'h0, 16'h0);
    tick();
    reset = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    tick();
    total++;
    if ({bus.rd_valid, bus.rd_data} !== {1'b0, 16'h0}) begin
      bad++; $display("FAIL rstmid_rv got rv=%b rd=%h want 0 0000", bus.rd_valid, bus.rd_data);
    end
    reset = 1'b0;
    tick();
    total++;
    if (bus.rd_valid !== 1'b0) begin
      bad++; $display("FAIL rstmid_rv_after got rv=%b want=0", bus.rd_valid);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    test_reset();
    test_single_read();
    test_write_idle();
    test_both_grant();
    test_starvation();
    test_raw_buffered();
    test_raw_same_cycle();
    test_full_write_read();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
